// File: rtl/frame_read_ctrl_if.sv
// RAM read port and pixel stream bundle for frame_read_ctrl.
// master = controller side; slave = RAM + downstream side.
interface frame_read_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int ROW_W  = 10,
    parameter int COL_W  = 7
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [ROW_W-1:0]  counter_row;
    logic [COL_W-1:0]  counter_col;

    modport master (
        output mem_addr,
        output mem_re,
        input  mem_data,
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output counter_row,
        output counter_col
    );

    modport slave (
        input  mem_addr,
        input  mem_re,
        output mem_data,
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  counter_row,
        input  counter_col
    );
endinterface

// File: rtl/frame_read_ctrl.sv
// Raster-order frame reader: issues RAM reads and streams tagged
// pixels through a 2-entry skid FIFO under valid/ready backpressure.
module frame_read_ctrl #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int ROW_W     = 10,
    parameter int COL_W     = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
    input  logic [COL_W-1:0] num_cols,
    output logic             busy,
    output logic             finish,
    frame_read_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state;

    logic [ROW_W-1:0]  rows_q;
    logic [COL_W-1:0]  cols_q;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_addr;

    logic              inflight;
    logic [ROW_W-1:0]  if_row;
    logic [COL_W-1:0]  if_col;

    logic [DATA_W-1:0] buf_data [2];
    logic [ROW_W-1:0]  buf_row  [2];
    logic [COL_W-1:0]  buf_col  [2];
    logic              rd_idx;
    logic              wr_idx;
    logic [1:0]        occ;

    logic              pop;
    logic              issue;
    logic              last_rd;
    logic              col_end;
    logic [2:0]        pending;

    always_comb begin
        pop     = (occ != 2'd0) && bus.pix_ready;
        pending = 3'(occ) + 3'(inflight) - 3'(pop);
        issue   = (state == ISSUE) && (pending < 3'd2);
        col_end = (rd_col == cols_q - COL_W'(1));
        last_rd = col_end && (rd_row == rows_q - ROW_W'(1));
    end

    // Address shows the pointer while reading, else the last read issued.
    assign bus.mem_re      = issue;
    assign bus.mem_addr    = issue ? ptr : last_addr;
    assign bus.pix_valid   = (occ != 2'd0);
    assign bus.pix_data    = buf_data[rd_idx];
    assign bus.counter_row = buf_row[rd_idx];
    assign bus.counter_col = buf_col[rd_idx];
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            finish    <= 1'b0;
            rows_q    <= '0;
            cols_q    <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            ptr       <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
            if_row    <= '0;
            if_col    <= '0;
            rd_idx    <= 1'b0;
            wr_idx    <= 1'b0;
            occ       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_row[i]  <= '0;
                buf_col[i]  <= '0;
            end
        end else begin
            finish   <= 1'b0;
            inflight <= issue;

            // RAM data arrives one cycle after its read; tag it with
            // the coordinates captured at issue time.
            if (inflight) begin
                buf_data[wr_idx] <= bus.mem_data;
                buf_row[wr_idx]  <= if_row;
                buf_col[wr_idx]  <= if_col;
                wr_idx           <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            occ <= occ + 2'(inflight) - 2'(pop);

            unique case (state)
                IDLE: begin
                    if (start) begin
                        rows_q <= num_rows;
                        cols_q <= num_cols;
                        if (num_rows == '0 || num_cols == '0) begin
                            finish <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            rd_row <= '0;
                            rd_col <= '0;
                            ptr    <= ADDR_W'(BASE_ADDR);
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        if_row    <= rd_row;
                        if_col    <= rd_col;
                        last_addr <= ptr;
                        ptr       <= ptr + ADDR_W'(1);
                        if (col_end) begin
                            rd_col <= '0;
                            rd_row <= rd_row + ROW_W'(1);
                        end else begin
                            rd_col <= rd_col + COL_W'(1);
                        end
                        if (last_rd) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && occ == 2'd1 && !inflight) begin
                        state  <= IDLE;
                        finish <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Scoreboard bench for frame_read_ctrl: directed cycle-mask runs on a
// BASE_ADDR=0 instance and a long random-backpressure frame at base 100.
module tb_frame_read_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       act = 1'b0;
    logic [9:0] num_rows = '0;
    logic [6:0] num_cols = '0;
    logic       pix_ready = 1'b1;
    logic       busy0, finish0, busy1, finish1;

    int asserts = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frame_read_ctrl_if #(.ADDR_W(19), .DATA_W(8), .ROW_W(10), .COL_W(7)) b0 ();
    frame_read_ctrl_if #(.ADDR_W(19), .DATA_W(8), .ROW_W(10), .COL_W(7)) b1 ();

    frame_read_ctrl #(.ADDR_W(19), .DATA_W(8), .ROW_W(10), .COL_W(7),
                      .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start && !act),
        .num_rows(num_rows), .num_cols(num_cols),
        .busy(busy0), .finish(finish0), .bus(b0));

    frame_read_ctrl #(.ADDR_W(19), .DATA_W(8), .ROW_W(10), .COL_W(7),
                      .BASE_ADDR(100)) dut1 (
        .clk(clk), .rst(rst), .start(start && act),
        .num_rows(num_rows), .num_cols(num_cols),
        .busy(busy1), .finish(finish1), .bus(b1));

    function automatic logic [7:0] ram_val(input logic [18:0] a);
        return 8'(a + 19'd16);
    endfunction

    assign b0.pix_ready = pix_ready;
    assign b1.pix_ready = pix_ready;

    always @(posedge clk) begin
        if (b0.mem_re) b0.mem_data <= ram_val(b0.mem_addr);
        if (b1.mem_re) b1.mem_data <= ram_val(b1.mem_addr);
    end

    logic        m_re, m_valid, m_busy, m_fin;
    logic [18:0] m_addr;
    logic [7:0]  m_data;
    logic [9:0]  m_row;
    logic [6:0]  m_col;

    assign m_re    = act ? b1.mem_re      : b0.mem_re;
    assign m_addr  = act ? b1.mem_addr    : b0.mem_addr;
    assign m_valid = act ? b1.pix_valid   : b0.pix_valid;
    assign m_data  = act ? b1.pix_data    : b0.pix_data;
    assign m_row   = act ? b1.counter_row : b0.counter_row;
    assign m_col   = act ? b1.counter_col : b0.counter_col;
    assign m_busy  = act ? busy1          : busy0;
    assign m_fin   = act ? finish1        : finish0;

    logic [18:0] aq [$];
    logic [31:0] pq [$];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        asserts++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e,
                     $time);
        end
    endtask

    task automatic exp_frame(input int base, input int r, input int c);
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                logic [18:0] a;
                a = 19'(base + i * c + j);
                aq.push_back(a);
                pq.push_back(32'({ram_val(a), 10'(i), 7'(j)}));
            end
        end
    endtask

    int          rd_cnt = 0;
    int          pix_cnt = 0;
    logic [18:0] last_rd = '0;
    logic [31:0] last_pix = '0;
    logic        hold = 1'b0;
    logic [31:0] prev = '0;

    always @(negedge clk) begin
        logic [31:0] cur;
        cur = 32'({m_data, m_row, m_col});
        if (rst) begin
            hold = 1'b0;
            rd_cnt = 0;
            pix_cnt = 0;
            aq.delete();
            pq.delete();
        end else begin
            if (m_re) begin
                if (aq.size() == 0) chk("unexpected_read", 32'(m_addr), 32'hFFFF_FFFF);
                else chk("read_addr", 32'(m_addr), 32'(aq.pop_front()));
                last_rd = m_addr;
                rd_cnt++;
            end
            if (hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_pixel", cur, prev);
            end
            if (m_valid && pix_ready) begin
                if (pq.size() == 0) chk("unexpected_pixel", cur, 32'hFFFF_FFFF);
                else chk("pixel", cur, pq.pop_front());
                last_pix = cur;
                pix_cnt++;
            end
            if (rd_cnt - pix_cnt > 2) chk("outstanding", 32'(rd_cnt - pix_cnt), 32'd2);
            hold = m_valid && !pix_ready;
            prev = cur;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input string n,
                       input int r, input int cl, input int ar, input int ac,
                       input logic [15:0] st, input logic [15:0] acc,
                       input logic [15:0] rs, input logic [15:0] rdy,
                       input logic [15:0] ere, input logic [15:0] eval,
                       input logic [15:0] ebusy, input logic [15:0] efin,
                       input bit zchk);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            start = st[c];
            rst = rs[c];
            pix_ready = rdy[c];
            num_rows = 10'(c == 0 ? r : ar);
            num_cols = 7'(c == 0 ? cl : ac);
            if (acc[c]) begin
                if (c == 0) exp_frame(0, r, cl);
                else exp_frame(0, ar, ac);
            end
            @(negedge clk);
            chk({n, "_busy"}, 32'(m_busy), 32'(ebusy[c]));
            chk({n, "_finish"}, 32'(m_fin), 32'(efin[c]));
            chk({n, "_mem_re"}, 32'(m_re), 32'(ere[c]));
            chk({n, "_valid"}, 32'(m_valid), 32'(eval[c]));
            if (zchk && c == 6) begin
                chk({n, "_zero_addr"}, 32'(m_addr), 32'd0);
                chk({n, "_zero_pix"}, 32'({m_data, m_row, m_col}), 32'd0);
            end
        end
        start = 1'b0;
        chk({n, "_reads_left"}, 32'(aq.size()), 32'd0);
        chk({n, "_pix_left"}, 32'(pq.size()), 32'd0);
    endtask

    initial begin
        bit done;
        do_reset();

        run("basic", 2, 3, 2, 3, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF,
            16'h007E, 16'h01F8, 16'h01FE, 16'h0200, 1'b0);
        run("stall", 2, 3, 2, 3, 16'h0001, 16'h0001, 16'h0000, 16'hFF07,
            16'h0F06, 16'h3FF8, 16'h3FFE, 16'h4000, 1'b0);
        run("rows0", 0, 3, 0, 3, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF,
            16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0);
        run("cols0", 2, 0, 2, 0, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF,
            16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0);
        run("reset", 4, 4, 1, 1, 16'h0101, 16'h0101, 16'h0020, 16'hFFFF,
            16'h023E, 16'h0838, 16'h0E3E, 16'h1000, 1'b1);
        run("busy_start", 2, 3, 5, 5, 16'h0011, 16'h0001, 16'h0000, 16'hFFFF,
            16'h007E, 16'h01F8, 16'h01FE, 16'h0200, 1'b0);
        run("fin_start", 2, 3, 1, 2, 16'h0201, 16'h0201, 16'h0000, 16'hFFFF,
            16'h0C7E, 16'h31F8, 16'h3DFE, 16'h4200, 1'b0);

        do_reset();
        act = 1'b1;
        @(posedge clk); #1;
        num_rows = 10'd3;
        num_cols = 7'd127;
        start = 1'b1;
        exp_frame(100, 3, 127);
        @(posedge clk); #1;
        start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            pix_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_fin) done = 1'b1;
            @(posedge clk); #1;
        end
        chk("big_finish_seen", 32'(done), 32'd1);
        chk("big_pix_count", 32'(pix_cnt), 32'd381);
        chk("big_last_addr", 32'(last_rd), 32'd480);
        chk("big_last_coord", last_pix & 32'h1FFFF, 32'({10'd2, 7'd126}));
        chk("big_reads_left", 32'(aq.size()), 32'd0);
        chk("big_pix_left", 32'(pq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule

// File: doc/frame_read_ctrl.md
Name: frame_read_ctrl

Overview:
Read-side initiator for the single-port synchronous feature-map RAM. On start, it sweeps a num_rows x num_cols frame in raster order and drives mem_addr/mem_re into the RAM. It captures the RAM's registered read data one cycle after each read and streams pixels, tagged with row/column coordinates, to the downstream conv engine over a valid/ready interface. A 2-entry output buffer absorbs backpressure without losing or duplicating reads.

Parameters:
ADDR_W, 19, RAM address width
DATA_W, 8, pixel width
ROW_W, 10, row counter width
COL_W, 7, column counter width
BASE_ADDR, 0, RAM address of pixel (0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a frame; sampled only in IDLE
num_rows  in  ROW_W  frame rows; latched on accepted start
num_cols  in  COL_W  frame columns; latched on accepted start
busy  out  1  frame in progress
finish  out  1  one-cycle pulse when the frame completes
mem_addr  out  ADDR_W  RAM read address
mem_re  out  1  RAM read enable
mem_data  in  DATA_W  RAM read data, valid the cycle after mem_re
pix_data  out  DATA_W  output pixel
pix_valid  out  1  pix_data/coordinates valid
pix_ready  in  1  downstream accepts the pixel when valid&&ready
counter_row  out  ROW_W  row of current pix_data
counter_col  out  COL_W  column of current pix_data

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, buffer is emptied, and the in-flight read flag is cleared. Reset has priority over every other input in any state. A read already in flight when rst is asserted is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: start=1 latches the dimensions.
  - If num_rows==0 or num_cols==0: pulse finish the next cycle, stay in IDLE, issue no reads, never raise busy.
  - Otherwise go to ISSUE with rd_row=0, rd_col=0, and the address pointer at BASE_ADDR.
- ISSUE: mem_re=1 whenever (buffer occupancy + inflight − pop) < 2, where pop = pix_valid && pix_ready.
  - mem_addr equals the pointer. The pointer increments by 1 per issued read; it is never computed with a multiply.
  - rd_col increments per read. At num_cols−1 it wraps to 0 and rd_row increments.
  - Issuing the read at (num_rows−1, num_cols−1) moves the FSM to DRAIN.
  - mem_re=0 whenever a read is not issued. mem_addr holds its last value.
- Inflight flag is set for the cycle after each read. In that cycle, mem_data is pushed into the buffer together with the coordinates of that read.
- The buffer is a 2-entry FIFO of {data, row, col}.
  - pix_valid = buffer non-empty. pix_data, counter_row and counter_col show the head entry.
  - Outputs hold stable while pix_valid && !pix_ready.
  - Push and pop may occur in the same cycle. The issue rule guarantees the buffer never overflows.
- DRAIN: no reads are issued. When the final pixel handshakes, go to IDLE and assert finish for exactly one cycle, in the next cycle.
- busy = 1 in ISSUE and DRAIN. busy is 0 in the cycle finish is high.
- start while busy is ignored. start in the finish cycle is accepted (FSM is already in IDLE).
- Latency, with start high in cycle 0 and pix_ready=1:
  - mem_re=1 with mem_addr=BASE_ADDR in cycle 1.
  - pix_valid=1 in cycle 3.
  - Steady throughput is 1 pixel/cycle.
- Last address = BASE_ADDR + num_rows*num_cols − 1. The address does not wrap within ADDR_W for legal dimensions (maximum 1023*127).

Test Plan:
- 2x3 frame, BASE_ADDR=0, RAM preloaded with 0x10..0x15, pix_ready=1, start in cycle 0 -> mem_re cycles 1-6 with addr 0..5; pix_valid cycles 3-8 with data 0x10..0x15 and coords (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); finish high only in cycle 9; busy high in cycles 1-8.
- Same frame with pix_ready=0 in cycles 3-7 -> at most 2 outstanding reads (mem_re pauses); pix_data stays 0x10 with coords (0,0) held through cycle 7; all six pixels delivered once, in order, with no duplicates.
- num_rows=0 (and separately num_cols=0) with start in cycle 0 -> mem_re never asserts, busy stays 0, finish high in cycle 1 only.
- rst asserted in cycle 5 of a 4x4 frame -> all outputs 0 in cycle 6 and no pix_valid afterwards; a new start in cycle 8 issues mem_addr=BASE_ADDR again in cycle 9.
- start pulsed again in cycle 4 of a 2x3 frame with different dims -> ignored; original sequence unchanged. A start in the finish cycle begins a new frame the next cycle.
- 3x127 frame, BASE_ADDR=100, random pix_ready -> column wraps 126→0 with row increment; final pixel at addr 480 with coords (2,126); pixel count is 381.
